// File: rtl/b2_sequential_comparator.sv
// rtl/b2_sequential_comparator.sv - multi-cycle chunked comparator with soc/eoc handshake
// Subtracts K bits per clock, LSB chunk first, and emits the one-hot eq/gr/lr flag triple.
module b2_sequential_comparator #(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic         mode,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         eoc,
  output logic         flag_eq,
  output logic         flag_gr,
  output logic         flag_lr
);

  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  x_sh;
  logic [N-1:0]  y_sh;
  logic          mode_r;
  logic          sign_x;
  logic          sign_y;
  logic          borrow;
  logic          nz;
  logic [CW-1:0] cnt;

  logic [K:0]    diff;
  logic          borrow_out;
  logic          nz_next;
  logic          last_step;
  logic          res_lr;
  logic          res_eq;

  // One chunk of the ripple subtract; bit K of the zero-extended difference is the borrow-out.
  always_comb begin
    diff       = {1'b0, x_sh[K-1:0]} - {1'b0, y_sh[K-1:0]} - {{K{1'b0}}, borrow};
    borrow_out = diff[K];
    nz_next    = nz | (diff[K-1:0] != '0);
    last_step  = (cnt == CW'(STEPS - 1));
    if (mode_r) begin
      res_lr = sign_x ^ sign_y ^ borrow_out;
      res_eq = ~nz_next;
    end else begin
      res_lr = borrow_out;
      res_eq = ~nz_next & ~borrow_out;
    end
  end

  assign eoc = (state != S_CALC);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= S_IDLE;
      x_sh    <= '0;
      y_sh    <= '0;
      mode_r  <= 1'b0;
      sign_x  <= 1'b0;
      sign_y  <= 1'b0;
      borrow  <= 1'b0;
      nz      <= 1'b0;
      cnt     <= '0;
      flag_eq <= 1'b0;
      flag_gr <= 1'b0;
      flag_lr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (soc) begin
            x_sh    <= x;
            y_sh    <= y;
            mode_r  <= mode;
            sign_x  <= x[N-1];
            sign_y  <= y[N-1];
            borrow  <= 1'b0;
            nz      <= 1'b0;
            cnt     <= '0;
            flag_eq <= 1'b0;
            flag_gr <= 1'b0;
            flag_lr <= 1'b0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          borrow <= borrow_out;
          nz     <= nz_next;
          x_sh   <= x_sh >> K;
          y_sh   <= y_sh >> K;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            flag_lr <= res_lr;
            flag_eq <= res_eq;
            flag_gr <= ~res_lr & ~res_eq;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // soc must drop before another comparison can be accepted.
          if (!soc) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
